// File: rtl/wb_slave_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_responder_pkg
// Description : Shared types and constants for the Wishbone slave responder:
//               FSM state encoding, LFSR geometry, address-LSB helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_slave_responder_pkg;

    // Responder FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam int          c_lfsr_width = 16;
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;

    // Number of byte-offset address bits below the word index
    function automatic int adr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_if
// Description : Wishbone classic-cycle bus bundle with initiator (master)
//               and responder (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADR;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic                    CYC;
    logic                    STB;
    logic                    WE;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic                    ACK;
    logic                    ERR;

    modport master (
        output ADR, DAT_W, CYC, STB, WE, SEL,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, CYC, STB, WE, SEL,
        output DAT_R, ACK, ERR
    );
endinterface
`default_nettype wire

// File: rtl/wb_slave_responder_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_responder_lfsr
// Description : Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used
//               to jitter the responder wait count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_responder_lfsr
    import wb_slave_responder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_lfsr_width-1:0] seed,
    output logic [c_lfsr_width-1:0] out
);

    logic [c_lfsr_width-1:0] r_lfsr;
    logic                    w_fb;

    assign w_fb = ^(r_lfsr & c_lfsr_taps);

    // Shift left every cycle, feedback enters at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= seed;
        end else begin
            r_lfsr <= {r_lfsr[c_lfsr_width-2:0], w_fb};
        end
    end

    assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/wb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_responder
// Description : Wishbone classic-cycle slave backed by a byte-lane word
//               memory. Programmable wait states, ERR for addresses beyond
//               the memory, transaction counter.
//               Optional macro WB_SLAVE_RESPONDER_RANDOM_WAIT_EN adds an
//               LFSR-driven 0..7 extra wait cycles (saturating at 255).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_responder
    import wb_slave_responder_pkg::*;
#(
    parameter int          WB_ADDR_WIDTH = 32,
    parameter int          WB_DATA_WIDTH = 32,   // 32 or 64
    parameter int          MEM_ADDR_BITS = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    wb_if.slave         s,
    input  logic [7:0]  wait_states,
    output logic        busy,
    output logic [31:0] txn_count
);

    localparam int c_sel_w   = WB_DATA_WIDTH / 8;
    localparam int c_adr_lsb = adr_lsb(WB_DATA_WIDTH);
    localparam int c_idx_top = MEM_ADDR_BITS + c_adr_lsb;
    localparam int c_depth   = 1 << MEM_ADDR_BITS;

    state_t                     r_state;
    state_t                     w_state_n;
    logic [7:0]                 r_wcnt;
    logic [7:0]                 w_wcnt_n;
    logic                       w_resp_go;
    logic [7:0]                 w_eff_wait;

    // Latched request
    logic                       r_we;
    logic [c_sel_w-1:0]         r_sel;
    logic [WB_DATA_WIDTH-1:0]   r_dat_w;
    logic [MEM_ADDR_BITS-1:0]   r_idx;
    logic                       r_oor;

    // Incoming request decode
    logic [MEM_ADDR_BITS-1:0]   w_in_idx;
    logic                       w_in_oor;

    // Request being answered: live bus in IDLE (zero-wait), latched otherwise
    logic                       w_req_we;
    logic [c_sel_w-1:0]         w_req_sel;
    logic [WB_DATA_WIDTH-1:0]   w_req_dat;
    logic [MEM_ADDR_BITS-1:0]   w_req_idx;
    logic                       w_req_oor;
    logic                       w_mem_we;

    logic                       r_ack;
    logic                       r_err;
    logic [WB_DATA_WIDTH-1:0]   r_dat_r;
    logic [31:0]                r_txn;

    logic [WB_DATA_WIDTH-1:0]   r_mem [c_depth];

`ifdef WB_SLAVE_RESPONDER_RANDOM_WAIT_EN
    logic [c_lfsr_width-1:0]    w_lfsr;
    logic [8:0]                 w_wait_sum;
    logic [12:0]                w_unused_lfsr_hi;

    wb_slave_responder_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (w_lfsr)
    );

    assign w_unused_lfsr_hi = w_lfsr[15:3];
    assign w_wait_sum       = {1'b0, wait_states} + {6'd0, w_lfsr[2:0]};
    assign w_eff_wait       = w_wait_sum[8] ? 8'hFF : w_wait_sum[7:0];
`else
    localparam logic [15:0] c_unused_seed = LFSR_SEED;
    assign w_eff_wait = wait_states;
`endif

    assign w_in_idx = s.ADR[c_idx_top-1:c_adr_lsb];
    assign w_in_oor = (s.ADR >> c_idx_top) != '0;

    assign w_req_we  = (r_state == IDLE) ? s.WE    : r_we;
    assign w_req_sel = (r_state == IDLE) ? s.SEL   : r_sel;
    assign w_req_dat = (r_state == IDLE) ? s.DAT_W : r_dat_w;
    assign w_req_idx = (r_state == IDLE) ? w_in_idx : r_idx;
    assign w_req_oor = (r_state == IDLE) ? w_in_oor : r_oor;

    // Reset in the same cycle as RESP entry drops the pending write
    assign w_mem_we = w_resp_go & w_req_we & ~w_req_oor & ~rst;

    // Next-state logic; w_resp_go marks the edge that enters RESP
    always_comb begin
        w_state_n = r_state;
        w_wcnt_n  = r_wcnt;
        w_resp_go = 1'b0;
        case (r_state)
            IDLE: begin
                if (s.CYC && s.STB) begin
                    w_wcnt_n = w_eff_wait;
                    if (w_eff_wait == 8'd0) begin
                        w_state_n = RESP;
                        w_resp_go = 1'b1;
                    end else begin
                        w_state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!s.CYC) begin
                    w_state_n = IDLE;
                    w_wcnt_n  = 8'd0;
                end else if (r_wcnt <= 8'd1) begin
                    w_state_n = RESP;
                    w_wcnt_n  = 8'd0;
                    w_resp_go = 1'b1;
                end else begin
                    w_wcnt_n = r_wcnt - 8'd1;
                end
            end
            RESP: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
                w_wcnt_n  = 8'd0;
            end
        endcase
    end

    // State, wait counter, response strobes, read data and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wcnt  <= 8'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_r <= '0;
            r_txn   <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_wcnt  <= w_wcnt_n;
            r_ack   <= w_resp_go & ~w_req_oor;
            r_err   <= w_resp_go &  w_req_oor;
            if (w_resp_go) begin
                if (w_req_oor) begin
                    r_dat_r <= '0;
                end else if (!w_req_we) begin
                    r_dat_r <= r_mem[w_req_idx];
                end
            end
            if (r_state == RESP) begin
                r_txn <= r_txn + 32'd1;
            end
        end
    end

    // Capture the request when it is accepted in IDLE
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && s.CYC && s.STB) begin
            r_we    <= s.WE;
            r_sel   <= s.SEL;
            r_dat_w <= s.DAT_W;
            r_idx   <= w_in_idx;
            r_oor   <= w_in_oor;
        end
    end

    // Byte-lane memory write; contents are not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_sel_w; b++) begin
                if (w_req_sel[b]) begin
                    r_mem[w_req_idx][b*8 +: 8] <= w_req_dat[b*8 +: 8];
                end
            end
        end
    end

    assign s.ACK     = r_ack;
    assign s.ERR     = r_err;
    assign s.DAT_R   = r_dat_r;
    assign busy      = (r_state != IDLE);
    assign txn_count = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_slave_responder
// Description : Self-checking bench for wb_slave_responder: scoreboard of
//               expected responses plus a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slave_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wait_states;
    logic        busy;
    logic [31:0] txn_count;

    always #5 clk = ~clk;

    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_slave_responder #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_ADDR_BITS (10),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (bus),
        .wait_states (wait_states),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int unsigned];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_txn = 0;

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic idle_bus();
        bus.CYC   = 1'b0;
        bus.STB   = 1'b0;
        bus.WE    = 1'b0;
        bus.ADR   = 32'h0;
        bus.DAT_W = 32'h0;
        bus.SEL   = 4'h0;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input logic [7:0] ws);
        wait_states = ws;
        bus.ADR     = adr;
        bus.DAT_W   = wdat;
        bus.SEL     = sel;
        bus.WE      = we;
        bus.CYC     = 1'b1;
        bus.STB     = 1'b1;
    endtask

    // Full transaction: called and returns at a negedge
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [7:0] ws, input string tag);
        exp_t        e;
        int          c;
        int          busy_cnt;
        logic        seen;
        int unsigned idx;
        idx        = adr[11:2];
        e.is_err   = (adr[31:12] != 20'h0);
        e.chk_data = e.is_err || !we;
        e.data     = 32'h0;
        e.lat      = int'(ws) + 1;
        if (!e.is_err) begin
            if (we) model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, wdat, sel);
            else    e.data     = model.exists(idx) ? model[idx] : 32'h0;
        end
        sb.push_back(e);
        drive(we, adr, wdat, sel, ws);
        seen = 1'b0; busy_cnt = 0; c = 0;
        while (!seen && c < int'(ws) + 16) begin
            @(posedge clk); @(negedge clk);
            c++;
            if (busy) busy_cnt++;
            if (bus.ACK || bus.ERR) seen = 1'b1;
        end
        idle_bus();
        if (!seen) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            e = sb.pop_front();
        end else begin
            e = sb.pop_front();
            chk({tag, "_ackerr"}, {bus.ACK, bus.ERR}, e.is_err ? 2'b01 : 2'b10);
            if (e.chk_data) chk({tag, "_data"}, bus.DAT_R, e.data);
            chk({tag, "_latency"}, c, e.lat);
            chk({tag, "_busy_cycles"}, busy_cnt, c);
            exp_txn++;
        end
        @(posedge clk); @(negedge clk);
        chk({tag, "_resp_one_cycle"}, {bus.ACK, bus.ERR}, 2'b00);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_txn"}, txn_count, exp_txn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        seen;
        rst = 1'b1;
        wait_states = 8'd0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   bus.ACK,   1'b0);
        chk("rst_err",   bus.ERR,   1'b0);
        chk("rst_datr",  bus.DAT_R, 32'h0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_txn",   txn_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read, zero wait
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, "t1_wr");
        do_xfer(1'b0, 32'h10, 32'h0,        4'hF, 8'd0, "t1_rd");
        // Partial lanes
        do_xfer(1'b1, 32'h10, 32'h12345678, 4'h3, 8'd0, "t2_wr");
        do_xfer(1'b0, 32'h10, 32'h0,        4'hF, 8'd0, "t2_rd");
        // Wait states
        do_xfer(1'b1, 32'h20, 32'hA5A5_0F0F, 4'hF, 8'd1, "t3_wr");
        do_xfer(1'b0, 32'h20, 32'h0,         4'hF, 8'd3, "t3_rd");
        // Out of range aliasing onto word 0
        do_xfer(1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 8'd0, "t4_pre");
        do_xfer(1'b1, 32'h1000, 32'h55,       4'hF, 8'd0, "t4_oor_wr");
        do_xfer(1'b0, 32'h1000, 32'h0,        4'hF, 8'd2, "t4_oor_rd");
        do_xfer(1'b0, 32'h0,    32'h0,        4'hF, 8'd0, "t4_rd0");
        do_xfer(1'b1, 32'h14,   32'h0BAD0BAD, 4'h0, 8'd0, "t4_sel0");
        do_xfer(1'b0, 32'h14,   32'h0,        4'hF, 8'd0, "t4_sel0_rd");

        // Abort by dropping CYC during WAIT
        do_xfer(1'b1, 32'h30, 32'h0BADCAFE, 4'hF, 8'd0, "t5_pre");
        drive(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 8'd5);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        idle_bus();
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (bus.ACK || bus.ERR) seen = 1'b1;
        end
        chk("t5_abort_noresp", seen, 1'b0);
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_txn", txn_count, exp_txn);
        do_xfer(1'b0, 32'h30, 32'h0, 4'hF, 8'd0, "t5_rd");

        // Reset during WAIT of a write
        do_xfer(1'b1, 32'h40, 32'h11111111, 4'hF, 8'd0, "t6_pre");
        drive(1'b1, 32'h40, 32'h99999999, 4'hF, 8'd5);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        idle_bus();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        exp_txn = 0;
        chk("t6_rst_ack",  bus.ACK,   1'b0);
        chk("t6_rst_busy", busy,      1'b0);
        chk("t6_rst_txn",  txn_count, 32'd0);
        do_xfer(1'b0, 32'h40, 32'h0, 4'hF, 8'd0, "t6_rd");

        // Randomised traffic over a small window
        for (int i = 0; i < 16; i++)
            do_xfer(1'b1, 32'h200 + 32'(i * 4), $urandom, 4'hF, 8'($urandom_range(0, 2)), "rnd_init");
        for (int i = 0; i < 24; i++) begin
            a = 32'h200 + 32'($urandom_range(0, 15) * 4);
            do_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 3)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_slave_responder.md
Name: wb_slave_responder

Overview:
Wishbone classic-cycle slave. It is the responder end of the wb_if protocol that wb_master_bfm drives as initiator.
- Backed by an internal word memory with byte-lane writes.
- Runtime-programmable wait states; error response for out-of-range addresses.
- Plugs into any interconnect slave port (s0/s1) in subsystem benches. Also usable as a small synthesizable scratch RAM.

Parameters:
WB_ADDR_WIDTH, 32, width of s.ADR.
WB_DATA_WIDTH, 32, width of s.DAT_W/s.DAT_R; SEL width = WB_DATA_WIDTH/8; must be 32 or 64.
MEM_ADDR_BITS, 10, log2 of memory depth in words.
LFSR_SEED, 16'hACE1, LFSR reset value; used only with the optional feature.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
s  interface  wb_if.slave  Wishbone slave port: ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, ACK, ERR.
wait_states  input  8  extra cycles inserted before ACK/ERR; sampled when a request is accepted.
busy  output  1  high while in WAIT or RESP.
txn_count  output  32  count of completed transactions (ACK or ERR); wraps at 2^32.

Behaviour:
- Reset (rst high at posedge): state=IDLE, ACK=0, ERR=0, DAT_R=0, busy=0, txn_count=0, wait counter=0. Memory contents are not reset.
- Word index = ADR[MEM_ADDR_BITS+ADDR_LSB-1:ADR_LSB], with ADR_LSB = log2(WB_DATA_WIDTH/8). Out of range = any ADR bit at or above MEM_ADDR_BITS+ADR_LSB set.
- IDLE: on posedge with CYC&STB:
  - latch ADR, WE, SEL, DAT_W;
  - load wcnt = wait_states;
  - go to WAIT if wait_states != 0, else RESP.
- WAIT:
  - CYC low -> abort: back to IDLE, no ACK/ERR, no write, txn_count unchanged.
  - Else decrement wcnt; when wcnt reaches 1 -> RESP.
- Entry into RESP (registered):
  - in range: ACK=1; write performs byte lanes per latched SEL (SEL=0 writes nothing but still ACKs); read drives DAT_R = mem[index].
  - out of range: ERR=1, ACK=0, DAT_R=0, no write.
- RESP: ACK/ERR high exactly one cycle; txn_count+1; unconditionally go to IDLE. STB during the RESP cycle is ignored, so back-to-back requests see one idle cycle.
- Latency: ACK/ERR asserted wait_states+1 cycles after the posedge that sampled the request.
- ACK and ERR are never high together. DAT_R holds its last value outside ACK and is meaningful only with ACK.
- rst mid-transaction: returns to IDLE at that edge. ACK/ERR low next cycle, pending write dropped.
- CTI/BTE, if present, are ignored; every beat is treated as a classic cycle.

Optional Feature:
WB_SLAVE_RESPONDER_RANDOM_WAIT_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, reset to LFSR_SEED) steps every cycle. Effective wait = wait_states + lfsr[2:0], saturating at 255.
- Undefined: no LFSR logic; wait is exactly wait_states and fully deterministic.

Decomposition:
- Package wb_slave_responder_pkg:
  - state enum {IDLE, WAIT, RESP};
  - LFSR tap mask and width constants;
  - function computing ADR_LSB from data width.
- One sub-module, wb_slave_responder_lfsr (clk, rst, seed, out[15:0]), instantiated only under the macro.
- Memory stays inline as a byte-enabled array.

Test Plan:
- Write 32'hDEADBEEF to 0x10, SEL=4'hF, wait_states=0 -> ACK one cycle, 1 cycle after request; read of 0x10 returns DEADBEEF; txn_count=2.
- Preload 0x10=DEADBEEF, write 32'h12345678 with SEL=4'h3 -> read returns 32'hDEAD5678.
- wait_states=3, read 0x20 -> ACK exactly 4 cycles after request; busy high for 4 cycles.
- MEM_ADDR_BITS=10, access 0x0000_1000 (write 0x55) -> ERR one cycle, ACK never, DAT_R=0; memory word 0 unchanged; txn_count+1.
- wait_states=5, drop CYC after 2 cycles -> no ACK/ERR; target word unchanged; txn_count unchanged; next request served normally.
- Assert rst during WAIT of a write -> ACK=0, busy=0 next cycle; write not performed; txn_count=0.
